// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO controller and its RAM geometry.
package fifo_pkg;

   localparam int FIFO_DEPTH       = 512;
   localparam int FIFO_ADDR_WIDTH  = 9;
   localparam int FIFO_DATA_WIDTH  = 18;
   localparam int FIFO_AFULL_LEVEL = 480;

endpackage

// File: rtl/pmi_ram_dp.sv
// Behavioural stand-in for the vendor pseudo dual-port RAM primitive.
// The read port always registers once (Q follows RdAddress one edge later);
// "reg" mode adds a second, resettable output register.
module pmi_ram_dp #(
   parameter int pmi_wr_addr_depth = 512,
   parameter int pmi_wr_addr_width = 9,
   parameter int pmi_wr_data_width = 18,
   parameter int pmi_rd_addr_depth = 512,
   parameter int pmi_rd_addr_width = 9,
   parameter int pmi_rd_data_width = 18,
   parameter     pmi_regmode       = "reg"
) (
   input  logic [pmi_wr_data_width-1:0] Data,
   input  logic [pmi_wr_addr_width-1:0] WrAddress,
   input  logic [pmi_rd_addr_width-1:0] RdAddress,
   input  logic                         WrClock,
   input  logic                         RdClock,
   input  logic                         WrClockEn,
   input  logic                         RdClockEn,
   input  logic                         WE,
   input  logic                         Reset,
   output logic [pmi_rd_data_width-1:0] Q
);

   localparam int MEM_DEPTH = (pmi_wr_addr_depth > pmi_rd_addr_depth) ?
                              pmi_wr_addr_depth : pmi_rd_addr_depth;

   logic [pmi_wr_data_width-1:0] mem [MEM_DEPTH];
   logic [pmi_rd_data_width-1:0] rd_q;
   logic                         unused_reset;

   // Reset only reaches the optional output register, never the array.
   assign unused_reset = Reset;

   // Write port: store Data when enabled and WE is high.
   always_ff @(posedge WrClock) begin
      if (WrClockEn && WE) begin
         mem[WrAddress] <= Data;
      end
   end

   // Read port: synchronous read of the addressed word.
   always_ff @(posedge RdClock) begin
      if (RdClockEn) begin
         rd_q <= pmi_rd_data_width'(mem[RdAddress]);
      end
   end

   generate
      if (pmi_regmode == "reg") begin : g_reg
         logic [pmi_rd_data_width-1:0] out_q;

         // Optional output pipeline register, cleared by Reset.
         always_ff @(posedge RdClock) begin
            if (Reset) begin
               out_q <= '0;
            end else if (RdClockEn) begin
               out_q <= rd_q;
            end
         end

         assign Q = out_q;
      end else begin : g_noreg
         assign Q = rd_q;
      end
   endgenerate

endmodule

// File: rtl/fifo_ctrl_dp.sv
// Single-clock FIFO controller around one pseudo dual-port RAM.
// Pointers carry one extra wrap bit so Full and Empty are distinguishable;
// all status outputs are registered from next-state values.
module fifo_ctrl_dp
   import fifo_pkg::*;
#(
   parameter int DEPTH       = FIFO_DEPTH,
   parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
   parameter int DATA_WIDTH  = FIFO_DATA_WIDTH,
   parameter int AFULL_LEVEL = FIFO_AFULL_LEVEL
) (
   input  logic                  Clock,
   input  logic                  Reset,
   input  logic                  WrEn,
   input  logic [DATA_WIDTH-1:0] WrData,
   input  logic                  RdEn,
   output logic [DATA_WIDTH-1:0] RdData,
   output logic                  RdValid,
   output logic                  Full,
   output logic                  Empty,
   output logic                  AlmostFull,
   output logic [ADDR_WIDTH:0]   Count,
   output logic                  Overflow,
   output logic                  Underflow
);

   localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0] AFULL_CNT = AFULL_LEVEL[ADDR_WIDTH:0];

   logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  afull_q, afull_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  rd_vld_q;
   logic                  wr_acc;
   logic                  rd_acc;
   logic [DATA_WIDTH-1:0] ram_q;
   logic [DATA_WIDTH-1:0] rd_hold_q;

   // Accept qualifiers use only registered flags, so a write into an empty
   // FIFO alongside a read accepts just the write (and vice versa when full).
   assign wr_acc = WrEn & ~full_q;
   assign rd_acc = RdEn & ~empty_q;

   // Next-state pointers, occupancy, flags and sticky error bits.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ONE;
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + ONE;
      end
      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + ONE;
         2'b01:   count_d = count_q - ONE;
         default: count_d = count_q;
      endcase
      empty_d = (wr_ptr_d == rd_ptr_d);
      full_d  = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
      afull_d = (count_d >= AFULL_CNT);
      ovf_d   = ovf_q | (WrEn & full_q);
      unf_d   = unf_q | (RdEn & empty_q);
   end

   // Control state register; Reset dominates any same-cycle request.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         afull_q  <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rd_vld_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         afull_q  <= afull_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         rd_vld_q <= rd_acc;
      end
   end

   // The RAM output re-reads every cycle, so capture the last delivered word
   // to keep RdData steady between strobes (no reset: data path only).
   always_ff @(posedge Clock) begin
      if (rd_vld_q) begin
         rd_hold_q <= ram_q;
      end
   end

   pmi_ram_dp #(
      .pmi_wr_addr_depth (DEPTH),
      .pmi_wr_addr_width (ADDR_WIDTH),
      .pmi_wr_data_width (DATA_WIDTH),
      .pmi_rd_addr_depth (DEPTH),
      .pmi_rd_addr_width (ADDR_WIDTH),
      .pmi_rd_data_width (DATA_WIDTH),
      .pmi_regmode       ("noreg")
   ) u_ram (
      .Data      (WrData),
      .WrAddress (wr_ptr_q[ADDR_WIDTH-1:0]),
      .RdAddress (rd_ptr_q[ADDR_WIDTH-1:0]),
      .WrClock   (Clock),
      .RdClock   (Clock),
      .WrClockEn (1'b1),
      .RdClockEn (1'b1),
      .WE        (wr_acc),
      .Reset     (Reset),
      .Q         (ram_q)
   );

   assign RdData     = rd_vld_q ? ram_q : rd_hold_q;
   assign RdValid    = rd_vld_q;
   assign Full       = full_q;
   assign Empty      = empty_q;
   assign AlmostFull = afull_q;
   assign Count      = count_q;
   assign Overflow   = ovf_q;
   assign Underflow  = unf_q;

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Directed bench for fifo_ctrl_dp with a read-data scoreboard.
module tb_fifo_ctrl_dp;

   localparam int DEPTH = 512;
   localparam int DW    = 18;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          WrEn;
   logic [DW-1:0] WrData;
   logic          RdEn;
   logic [DW-1:0] RdData;
   logic          RdValid;
   logic          Full;
   logic          Empty;
   logic          AlmostFull;
   logic [9:0]    Count;
   logic          Overflow;
   logic          Underflow;

   int            vectors     = 0;
   int            miscompares = 0;
   int            cyc         = 0;

   logic [DW-1:0] m[$];       // reference contents
   logic [DW-1:0] exp_d[$];   // scoreboard: expected read data
   int            exp_c[$];   // scoreboard: cycle the strobe is due
   bit            have_last = 1'b0;
   logic [DW-1:0] last_d;

   fifo_ctrl_dp dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .WrEn       (WrEn),
      .WrData     (WrData),
      .RdEn       (RdEn),
      .RdData     (RdData),
      .RdValid    (RdValid),
      .Full       (Full),
      .Empty      (Empty),
      .AlmostFull (AlmostFull),
      .Count      (Count),
      .Overflow   (Overflow),
      .Underflow  (Underflow)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // One clock of stimulus; the reference model decides what is accepted.
   task automatic step(input bit we, input logic [DW-1:0] wd, input bit re);
      bit full_m;
      bit empty_m;
      full_m  = (m.size() == DEPTH);
      empty_m = (m.size() == 0);
      WrEn    = we;
      WrData  = wd;
      RdEn    = re;
      if (re && !empty_m) begin
         exp_d.push_back(m.pop_front());
         exp_c.push_back(cyc + 1);
      end
      if (we && !full_m) m.push_back(wd);
      @(posedge Clock);
      #1;
      WrEn = 1'b0;
      RdEn = 1'b0;
   endtask

   task automatic reset_step(input bit we, input bit re);
      Reset  = 1'b1;
      WrEn   = we;
      RdEn   = re;
      WrData = 18'h3C3C3;
      m.delete();
      @(posedge Clock);
      have_last = 1'b0;
      #1;
      Reset = 1'b0;
      WrEn  = 1'b0;
      RdEn  = 1'b0;
   endtask

   task automatic monitor();
      logic [DW-1:0] e;
      int            c;
      forever begin
         @(negedge Clock);
         while (exp_c.size() > 0 && exp_c[0] < cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL rdvalid_missing: RdValid=0 at cycle %0d, expected RdValid=1 with 0x%0h",
                     exp_c[0], exp_d[0]);
            void'(exp_c.pop_front());
            void'(exp_d.pop_front());
         end
         if (RdValid === 1'b1) begin
            if (exp_c.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rdvalid_spurious: RdValid=1 data 0x%0h at cycle %0d, expected RdValid=0",
                        RdData, cyc);
            end else begin
               e = exp_d.pop_front();
               c = exp_c.pop_front();
               chk("rd_cycle", cyc, c);
               chk("rd_data", RdData, e);
            end
            have_last = 1'b1;
            last_d    = RdData;
         end else if (have_last) begin
            chk("rd_hold", RdData, last_d);
         end
      end
   endtask

   initial begin
      Reset  = 1'b1;
      WrEn   = 1'b0;
      RdEn   = 1'b0;
      WrData = '0;
      repeat (2) @(posedge Clock);
      #1;
      Reset = 1'b0;

      chk("rst_empty", Empty, 1);
      chk("rst_full", Full, 0);
      chk("rst_count", Count, 0);
      chk("rst_afull", AlmostFull, 0);
      chk("rst_ovf", Overflow, 0);
      chk("rst_unf", Underflow, 0);
      chk("rst_rdvalid", RdValid, 0);

      fork
         monitor();
      join_none

      // Basic write-then-read ordering
      for (int i = 1; i <= 4; i++) step(1'b1, 18'(i), 1'b0);
      chk("basic_count4", Count, 4);
      chk("basic_notempty", Empty, 0);
      for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("basic_empty", Empty, 1);
      chk("basic_count0", Count, 0);

      // Underflow, then simultaneous request while empty accepts only the write
      step(1'b0, '0, 1'b1);
      chk("unf_set", Underflow, 1);
      chk("unf_count", Count, 0);
      chk("unf_empty", Empty, 1);
      step(1'b1, 18'h2A5A5, 1'b1);
      chk("empty_wr_rd_count", Count, 1);
      chk("empty_wr_rd_notempty", Empty, 0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("unf_pair_empty", Empty, 1);
      step(1'b1, 18'h15A5A, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("unf_sticky", Underflow, 1);
      reset_step(1'b0, 1'b0);
      chk("unf_cleared", Underflow, 0);

      // Fill to Full, overflow, simultaneous request while full, drain
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 18'(i * 37 + 5), 1'b0);
         if (m.size() == 479) chk("afull_fill_479", AlmostFull, 0);
         if (m.size() == 480) chk("afull_fill_480", AlmostFull, 1);
      end
      chk("fill_full", Full, 1);
      chk("fill_count", Count, 512);
      chk("fill_ovf_clear", Overflow, 0);
      step(1'b1, 18'h3FFFF, 1'b0);
      chk("ovf_set", Overflow, 1);
      chk("ovf_count", Count, 512);
      chk("ovf_full", Full, 1);
      step(1'b1, 18'h3FFFE, 1'b1);
      chk("full_wr_rd_count", Count, 511);
      chk("full_wr_rd_notfull", Full, 0);
      while (m.size() > 0) begin
         step(1'b0, '0, 1'b1);
         if (m.size() == 480) chk("afull_drain_480", AlmostFull, 1);
         if (m.size() == 479) chk("afull_drain_479", AlmostFull, 0);
      end
      step(1'b0, '0, 1'b0);
      chk("drain_empty", Empty, 1);
      chk("drain_count", Count, 0);

      // Simultaneous traffic at Count=100 with pointer wrap
      reset_step(1'b0, 1'b0);
      for (int i = 0; i < 440; i++) step(1'b1, 18'(i), 1'b0);
      for (int i = 0; i < 440; i++) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 100; i++) step(1'b1, 18'(32'h20000 + i), 1'b0);
      chk("wrap_count100", Count, 100);
      for (int i = 0; i < 50; i++) begin
         step(1'b1, 18'(32'h30000 + i), 1'b1);
         chk("wrap_pair_count", Count, 100);
      end
      while (m.size() > 0) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("wrap_empty", Empty, 1);

      // Reset mid-burst with a read in flight
      reset_step(1'b0, 1'b0);
      step(1'b0, '0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 18'(i ^ 32'h155), 1'b0);
      step(1'b1, 18'h00777, 1'b0);
      while (m.size() > 38) step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      chk("mid_count37", Count, 37);
      chk("mid_ovf", Overflow, 1);
      chk("mid_unf", Underflow, 1);
      reset_step(1'b1, 1'b1);
      chk("mid_rst_count", Count, 0);
      chk("mid_rst_empty", Empty, 1);
      chk("mid_rst_full", Full, 0);
      chk("mid_rst_afull", AlmostFull, 0);
      chk("mid_rst_rdvalid", RdValid, 0);
      chk("mid_rst_ovf", Overflow, 0);
      chk("mid_rst_unf", Underflow, 0);
      step(1'b1, 18'h0ABCD, 1'b0);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b0);
      chk("post_rst_empty", Empty, 1);

      repeat (3) step(1'b0, '0, 1'b0);
      chk("scoreboard_drained", exp_d.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
